// File: rtl/tally_sched.sv
// tally_sched: round-robin scheduler sharing one combinational tally (popcount) unit among R requesters.
// Optional feature: define TALLY_SCHED_SAT_EN to saturate the job count and report overflow; default wraps.

module tally #(
  parameter int N = 6
) (
  input  logic [N-1:0] din_i,
  output logic [N:0]   onehot_o
);

  int unsigned cnt;

  always_comb begin
    cnt = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (din_i[i]) cnt++;
    end
    onehot_o = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      onehot_o[k] = (cnt == k);
    end
  end

endmodule

module tally_sched #(
  parameter int N  = 6,
  parameter int R  = 4,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         req_valid,
  output logic [R-1:0]         req_ready,
  input  logic [R*N-1:0]       req_data,
  input  logic [R-1:0]         req_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CW-1:0]        res_count,
  output logic [$clog2(R)-1:0] res_id,
  output logic                 res_ovf
);

  localparam int          IDW  = $clog2(R);
  localparam int          CNTW = $clog2(N + 1);
  localparam int unsigned RU   = R;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_q;
  logic [CW-1:0]   acc_q;
  logic [CW-1:0]   acc_d;
  logic            ovf_q;
  logic            ovf_d;
  logic [R-1:0]    req_ready_q;
  logic            res_valid_q;

  logic [N-1:0]    chunk [R];
  logic [N-1:0]    tally_in;
  logic [N:0]      onehot;
  logic [CNTW-1:0] c;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [R-1:0]    grant_vec;
  int unsigned     cand;
  logic            hs;
  logic [IDW-1:0]  ptr_nxt;

  genvar g;
  generate
    for (g = 0; g < R; g++) begin : g_chunk
      assign chunk[g] = req_data[g*N +: N];
    end
  endgenerate

  assign tally_in = chunk[gnt_q];

  tally #(.N(N)) u_tally (
    .din_i    (tally_in),
    .onehot_o (onehot)
  );

  always_comb begin
    c = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      if (onehot[k]) c |= CNTW'(k);
    end
  end

  // Rotating search starting at ptr_q; first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < RU; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= RU) cand = cand - RU;
      if (!pick_found && req_valid[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_vec           = '0;
    grant_vec[pick_idx] = 1'b1;
  end

  assign hs      = req_valid[gnt_q] & req_ready_q[gnt_q];
  assign ptr_nxt = (gnt_q == IDW'(R - 1)) ? '0 : gnt_q + 1'b1;

`ifdef TALLY_SCHED_SAT_EN
  logic [CW:0] sum;

  always_comb begin
    sum = {1'b0, acc_q} + {{(CW + 1 - CNTW){1'b0}}, c};
    if (sum[CW]) begin
      acc_d = '1;
      ovf_d = 1'b1;
    end else begin
      acc_d = sum[CW-1:0];
      ovf_d = ovf_q;
    end
  end
`else
  // Wrap build: ovf never sets, so res_ovf stays at its reset value of 0.
  always_comb begin
    acc_d = acc_q + {{(CW - CNTW){1'b0}}, c};
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      req_ready_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q       <= pick_idx;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            req_ready_q <= grant_vec;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (req_last[gnt_q]) begin
              req_ready_q <= '0;
              res_valid_q <= 1'b1;
              ptr_q       <= ptr_nxt;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          req_ready_q <= '0;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_count = acc_q;
  assign res_id    = gnt_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_tally_sched.sv
// Self-checking bench for tally_sched: vector table, directed corner sequences, randomized jobs vs. a queue model.
// Expectations follow TALLY_SCHED_SAT_EN when it is defined for the build.

module tb_tally_sched;

  localparam int N  = 6;
  localparam int R  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   req_last;
  logic           res_valid;
  logic           res_ready;
  logic [CW-1:0]  res_count;
  logic [1:0]     res_id;
  logic           res_ovf;

  always #5 clk = ~clk;

  tally_sched #(.N(N), .R(R), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         id;
    logic [5:0] d0;
    logic [5:0] d1;
    int         len;
    int         exp_cnt;
  } vec_t;

  vec_t       vecs [6];
  logic [5:0] jb   [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_chunk(input int id, input logic [N-1:0] d, input logic last);
    req_data[id*N +: N] = d;
    req_last[id]        = last;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Feeds one job for requester id; returns at the negedge after the last chunk was accepted.
  task automatic send_job(input int id, input int len);
    int w;
    req_valid[id] = 1'b1;
    for (int i = 0; i < len; i++) begin
      set_chunk(id, jb[i], (i == len - 1));
      w = 0;
      while (!req_ready[id] && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) begin
        checks++;
        failures++;
        $display("FAIL grant_timeout: requester %0d never got req_ready", id);
        break;
      end
      tick();
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  function automatic int exp_count(input int sum);
`ifdef TALLY_SCHED_SAT_EN
    return (sum > 15) ? 15 : sum;
`else
    return sum % 16;
`endif
  endfunction

  function automatic int exp_ovf(input int sum);
`ifdef TALLY_SCHED_SAT_EN
    return (sum > 15) ? 1 : 0;
`else
    return (sum < 0) ? 1 : 0;
`endif
  endfunction

  // Random-phase state
  logic [N-1:0] qd [R][$];
  logic         ql [R][$];
  int           drv_pos [R];
  logic         midjob  [R];
  int           e_id[$];
  int           e_cnt[$];
  int           e_ovf[$];

  initial begin
    int got_id[$];
    int got_t[$];
    int fair_exp [5];
    int cyc;
    int sum;
    int mptr;
    int mpos [R];
    int k;
    bit any;

    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    res_ready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_id",    res_id,    0);
    chk("rst_res_ovf",   res_ovf,   0);
    reset = 1'b0;
    tick();

    // Single job from requester 2: 101101 then 000111 -> 7
    req_valid[2] = 1'b1;
    set_chunk(2, 6'b101101, 1'b0);
    tick();
    chk("sj_grant", req_ready, 4'b0100);
    tick();
    set_chunk(2, 6'b000111, 1'b1);
    chk("sj_not_done", res_valid, 0);
    tick();
    chk("sj_res_valid", res_valid, 1);
    chk("sj_count", res_count, 7);
    chk("sj_id", res_id, 2);
    chk("sj_ovf", res_ovf, 0);
    chk("sj_ready_off", req_ready, 0);
    req_valid = '0;
    req_last  = '0;
    res_ready = 1'b1;
    tick();
    chk("sj_accepted", res_valid, 0);
    res_ready = 1'b0;

    // Vector table
    vecs[0] = '{0, 6'b000000, 6'b000000, 1, 0};
    vecs[1] = '{1, 6'b111111, 6'b000000, 1, 6};
    vecs[2] = '{3, 6'b100001, 6'b010000, 2, 3};
    vecs[3] = '{2, 6'b010101, 6'b101010, 2, 6};
    vecs[4] = '{0, 6'b111111, 6'b111110, 2, 11};
    vecs[5] = '{3, 6'b000001, 6'b000000, 1, 1};
    for (int i = 0; i < 6; i++) begin
      jb[0] = vecs[i].d0;
      jb[1] = vecs[i].d1;
      send_job(vecs[i].id, vecs[i].len);
      chk($sformatf("vec%0d_valid", i), res_valid, 1);
      chk($sformatf("vec%0d_count", i), res_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_id", i), res_id, vecs[i].id);
      chk($sformatf("vec%0d_ovf", i), res_ovf, 0);
      res_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_release", i), res_valid, 0);
      res_ready = 1'b0;
    end

    // Fairness: all requesters hold single-chunk jobs
    do_reset();
    for (int r = 0; r < R; r++) set_chunk(r, 6'(r + 1), 1'b1);
    req_valid = '1;
    res_ready = 1'b1;
    fair_exp  = '{0, 1, 2, 3, 0};
    cyc = 0;
    while (got_id.size() < 5 && cyc < 60) begin
      tick();
      cyc++;
      if (res_valid) begin
        got_id.push_back(int'(res_id));
        got_t.push_back(cyc);
      end
    end
    req_valid = '0;
    req_last  = '0;
    chk("fair_results", got_id.size(), 5);
    for (int i = 0; i < got_id.size() && i < 5; i++) begin
      chk($sformatf("fair_order%0d", i), got_id[i], fair_exp[i]);
      if (i > 0) chk($sformatf("fair_turn%0d", i), got_t[i] - got_t[i-1], 3);
    end

    // Backpressure with pending requesters
    do_reset();
    res_ready    = 1'b0;
    req_valid[1] = 1'b1;
    set_chunk(1, 6'b110000, 1'b1);
    tick();
    chk("bp_grant1", req_ready, 4'b0010);
    set_chunk(0, 6'b000001, 1'b1);
    set_chunk(3, 6'b000001, 1'b1);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), res_valid, 1);
      chk($sformatf("bp_hold_count%0d", i), res_count, 2);
      chk($sformatf("bp_hold_id%0d", i), res_id, 1);
      chk($sformatf("bp_hold_ready%0d", i), req_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_idle_valid", res_valid, 0);
    chk("bp_idle_ready", req_ready, 0);
    tick();
    chk("bp_next_grant", req_ready, 4'b1000);
    tick();
    chk("bp_r3_done", res_valid, 1);
    chk("bp_r3_id", res_id, 3);
    req_valid[3] = 1'b0;
    tick();
    tick();
    chk("bp_wrap_grant", req_ready, 4'b0001);
    req_valid = '0;
    req_last  = '0;

    // Overflow: three all-ones chunks (sum 18) with a 4-bit count
    do_reset();
    jb[0] = 6'b111111;
    jb[1] = 6'b111111;
    jb[2] = 6'b111111;
    send_job(1, 3);
    chk("ovf_valid", res_valid, 1);
    chk("ovf_count", res_count, exp_count(18));
    chk("ovf_flag", res_ovf, exp_ovf(18));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset during the second chunk of a job
    do_reset();
    req_valid[3] = 1'b1;
    set_chunk(3, 6'b111111, 1'b0);
    tick();
    chk("rm_grant3", req_ready, 4'b1000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_no_result", res_valid, 0);
    chk("rm_ready_off", req_ready, 0);
    chk("rm_count_clr", res_count, 0);
    req_valid[0] = 1'b1;
    set_chunk(0, 6'b000011, 1'b1);
    tick();
    chk("rm_grant0", req_ready, 4'b0001);
    chk("rm_still_none", res_valid, 0);
    tick();
    chk("rm_r0_valid", res_valid, 1);
    chk("rm_r0_count", res_count, 2);
    chk("rm_r0_id", res_id, 0);
    req_valid[0] = 1'b0;
    res_ready    = 1'b1;
    tick();
    tick();
    chk("rm_grant3_again", req_ready, 4'b1000);
    tick();
    set_chunk(3, 6'b111111, 1'b1);
    tick();
    chk("rm_r3_count", res_count, 12);
    chk("rm_r3_id", res_id, 3);
    req_valid = '0;
    req_last  = '0;

    // Randomized jobs against a round-robin queue model
    do_reset();
    for (int r = 0; r < R; r++) begin
      int nj;
      nj = $urandom_range(2, 5);
      for (int j = 0; j < nj; j++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int c = 0; c < len; c++) begin
          qd[r].push_back(6'($urandom));
          ql[r].push_back(c == len - 1);
        end
      end
      drv_pos[r] = 0;
      midjob[r]  = 1'b0;
      mpos[r]    = 0;
    end
    mptr = 0;
    any  = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < R; i++) begin
        k = (mptr + i) % R;
        if (mpos[k] < qd[k].size()) begin
          any = 1'b1;
          sum = 0;
          while (1) begin
            sum += $countones(qd[k][mpos[k]]);
            mpos[k]++;
            if (ql[k][mpos[k]-1]) break;
          end
          e_id.push_back(k);
          e_cnt.push_back(exp_count(sum));
          e_ovf.push_back(exp_ovf(sum));
          mptr = (k + 1) % R;
          break;
        end
      end
    end

    cyc = 0;
    while (e_id.size() > 0 && cyc < 5000) begin
      tick();
      cyc++;
      for (int r = 0; r < R; r++) begin
        if (drv_pos[r] < qd[r].size()) begin
          req_valid[r] = midjob[r] ? ($urandom_range(0, 3) != 0) : 1'b1;
          set_chunk(r, qd[r][drv_pos[r]], ql[r][drv_pos[r]]);
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
      res_ready = 1'($urandom_range(0, 1));
      if (!$onehot0(req_ready) || (res_valid && req_ready != 0)) begin
        chk("rand_ready_shape", req_ready, 0);
      end
      for (int r = 0; r < R; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          midjob[r] = !ql[r][drv_pos[r]];
          drv_pos[r]++;
        end
      end
      if (res_valid && res_ready) begin
        chk("rand_id", res_id, e_id[0]);
        chk("rand_count", res_count, e_cnt[0]);
        chk("rand_ovf", res_ovf, e_ovf[0]);
        void'(e_id.pop_front());
        void'(e_cnt.pop_front());
        void'(e_ovf.pop_front());
      end
    end
    chk("rand_all_results", e_id.size(), 0);
    req_valid = '0;
    req_last  = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
